inst_fetch_ctrl: RTL and testbench

- Memory-side responder for the CPU instruction fetch port.
- Accepts a fetch request on rom_ce_i/rom_addr_i and performs four byte-wide reads on the 8-bit RAM bus, where each read takes 2 cycles.
- Assembles the bytes little-endian and returns the 32-bit instruction with a one-cycle rom_valid_o pulse.
- Sits between the cpu top's rom_* port and the external mem_* bus; honours rdy_in pause.

---
 rtl/inst_fetch_ctrl_pkg.sv | 13 +
 rtl/inst_fetch_ctrl_word_assembler.sv | 36 +++
 rtl/inst_fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared widths and state encoding for the instruction fetch controller.
package inst_fetch_ctrl_pkg;

    localparam int AddrLen  = 32;
    localparam int InstLen  = 32;
    localparam int ByteCntW = 2;

    typedef enum logic {
        FetchIdle = 1'b0,
        FetchBusy = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_ctrl_word_assembler.sv
// Four-byte little-endian capture register; o_word shows the stored bytes with i_byte overlaid on i_lane.
// Single-cycle capture when i_en; i_clr has priority and wipes partial words.
module inst_fetch_ctrl_word_assembler
    import inst_fetch_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic [ByteCntW-1:0] i_lane,
    input  logic [7:0]          i_byte,
    output logic [InstLen-1:0]  o_word
);

    logic [InstLen-1:0] r_word;
    logic [InstLen-1:0] w_merged;

    always_comb begin
        w_merged = r_word;
        w_merged[{i_lane, 3'b000} +: 8] = i_byte;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word <= '0;
        end else if (i_clr) begin
            r_word <= '0;
        end else if (i_en) begin
            r_word <= w_merged;
        end
    end

    // The merged view lets the last byte land in rom_data_o on the same edge it is captured.
    assign o_word = w_merged;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch responder: four byte reads on the 8-bit RAM bus assembled into a 32-bit word.
// Latency: request in cycle 0, rom_valid_o pulse in cycle 6; INST_FETCH_HIT_EN adds a one-entry word buffer (hit valid next cycle).
// Backpressure: rdy_in low freezes every register; an address change or dropped rom_ce_i aborts the fetch.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = AddrLen,
    parameter int DATA_W = InstLen
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_in,
    input  logic              rom_ce_i,
    input  logic [ADDR_W-1:0] rom_addr_i,
    output logic [DATA_W-1:0] rom_data_o,
    output logic              rom_valid_o,
    output logic              busy_o,
    input  logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    localparam logic [ADDR_W-1:0] WordMask = ~ADDR_W'(3);

    fetch_state_t        r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_mem_a;
    logic [ByteCntW-1:0] r_cnt;
    logic                r_first;
    logic                r_valid;
    logic [DATA_W-1:0]   r_data;

    logic [ADDR_W-1:0]   w_req_base;
    logic                w_abort;
    logic                w_hit;
    logic                w_start;
    logic                w_capture;
    logic                w_last;
    logic [DATA_W-1:0]   w_hit_data;
    logic [DATA_W-1:0]   w_word;

    assign w_req_base = rom_addr_i & WordMask;
    assign w_abort    = !rom_ce_i || (w_req_base != r_base);
    assign w_start    = (r_state == FetchIdle) && rom_ce_i && !w_hit;
    // The first busy cycle only presents B on the bus; read data trails the address by one cycle.
    assign w_capture  = (r_state == FetchBusy) && !w_abort && !r_first;
    assign w_last     = w_capture && (r_cnt == ByteCntW'(3));

`ifdef INST_FETCH_HIT_EN
    logic [ADDR_W-1:0] r_tag;
    logic [DATA_W-1:0] r_tag_data;
    logic              r_tag_vld;

    assign w_hit      = r_tag_vld && (w_req_base == r_tag);
    assign w_hit_data = r_tag_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag      <= '0;
            r_tag_data <= '0;
            r_tag_vld  <= 1'b0;
        end else if (rdy_in && w_last) begin
            r_tag      <= r_base;
            r_tag_data <= w_word;
            r_tag_vld  <= 1'b1;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    inst_fetch_ctrl_word_assembler u_asm (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (rdy_in && w_start),
        .i_en   (rdy_in && w_capture),
        .i_lane (r_cnt),
        .i_byte (mem_din),
        .o_word (w_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FetchIdle;
            r_base  <= '0;
            r_mem_a <= '0;
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (rdy_in) begin
            r_valid <= 1'b0;
            case (r_state)
                FetchIdle: begin
                    if (rom_ce_i && w_hit) begin
                        r_valid <= 1'b1;
                        r_data  <= w_hit_data;
                    end else if (w_start) begin
                        r_state <= FetchBusy;
                        r_base  <= w_req_base;
                        r_mem_a <= w_req_base;
                        r_cnt   <= '0;
                        r_first <= 1'b1;
                    end
                end
                FetchBusy: begin
                    if (w_abort) begin
                        r_state <= FetchIdle;
                    end else if (r_first) begin
                        r_first <= 1'b0;
                        r_mem_a <= r_mem_a + ADDR_W'(1);
                    end else begin
                        r_cnt <= r_cnt + ByteCntW'(1);
                        // Address stops at B+3 while the last two bytes drain.
                        if (r_cnt < ByteCntW'(2)) begin
                            r_mem_a <= r_mem_a + ADDR_W'(1);
                        end
                        if (w_last) begin
                            r_state <= FetchIdle;
                            r_valid <= 1'b1;
                            r_data  <= w_word;
                        end
                    end
                end
                default: r_state <= FetchIdle;
            endcase
        end
    end

    assign rom_data_o  = r_data;
    assign rom_valid_o = r_valid;
    assign busy_o      = (r_state == FetchBusy);
    assign mem_a       = r_mem_a;
    assign mem_wr      = 1'b0;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed vector table, corner sequences, randomized run against a transaction model.
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] rom_data_o;
    logic        rom_valid_o;
    logic        busy_o;
    logic [7:0]  ram_q;
    logic [31:0] mem_a;
    logic        mem_wr;

    int tests = 0;
    int fails = 0;

    inst_fetch_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy_in      (rdy),
        .rom_ce_i    (ce),
        .rom_addr_i  (addr),
        .rom_data_o  (rom_data_o),
        .rom_valid_o (rom_valid_o),
        .busy_o      (busy_o),
        .mem_din     (ram_q),
        .mem_a       (mem_a),
        .mem_wr      (mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'd0:  return 8'h93;
            32'd1, 32'd2, 32'd3: return 8'h00;
            32'd4:  return 8'h13;
            32'd5:  return 8'h05;
            32'd6:  return 8'h10;
            32'd7:  return 8'h00;
            32'd8:  return 8'hB7;
            32'd9:  return 8'h12;
            32'd10: return 8'h34;
            32'd11: return 8'h56;
            32'd12: return 8'h6F;
            32'd13: return 8'h00;
            32'd14: return 8'h80;
            32'd15: return 8'h00;
            32'd16: return 8'h33;
            32'd17: return 8'h85;
            32'd18: return 8'hA5;
            32'd19: return 8'h00;
            default: return a[7:0] ^ a[31:24] ^ 8'hA5 ^ {a[3:0], a[7:4]};
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] b);
        return {ram_byte(b + 32'd3), ram_byte(b + 32'd2), ram_byte(b + 32'd1), ram_byte(b)};
    endfunction

    // RAM read data shows the byte addressed in the previous active cycle.
    always @(posedge clk) if (rdy) ram_q <= ram_byte(mem_a);

    task automatic compare(input string name, input logic [31:0] ema, input logic ev,
                           input logic eb, input logic [31:0] ed);
        tests++;
        if (mem_a !== ema || rom_valid_o !== ev || busy_o !== eb || rom_data_o !== ed || mem_wr !== 1'b0) begin
            fails++;
            $display("FAIL %s: got mem_a=%h vld=%b busy=%b data=%h wr=%b, want mem_a=%h vld=%b busy=%b data=%h wr=0",
                     name, mem_a, rom_valid_o, busy_o, rom_data_o, mem_wr, ema, ev, eb, ed);
        end
    endtask

    task automatic step(input string name, input logic c, input logic [31:0] a, input logic r,
                        input logic [31:0] ema, input logic ev, input logic eb, input logic [31:0] ed);
        ce = c; addr = a; rdy = r;
        @(negedge clk);
        compare(name, ema, ev, eb, ed);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic        rdy;
        logic [31:0] ma;
        logic        vld;
        logic        busy;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[32];

    localparam logic [31:0] W0  = 32'h0000_0093;
    localparam logic [31:0] W4  = 32'h0010_0513;
    localparam logic [31:0] W8  = 32'h5634_12B7;
    localparam logic [31:0] WC  = 32'h0080_006F;
    localparam logic [31:0] W10 = 32'h00A5_8533;

    // Transaction model: tracks active edges since acceptance; data comes straight from memory contents.
    logic        m_busy;
    logic [31:0] m_base;
    int          m_act;
    logic [31:0] m_ma;
    logic        m_vld;
    logic [31:0] m_data;
    logic        m_tagv;
    logic [31:0] m_tag;
    logic [31:0] m_tagd;

    task automatic model_reset();
        m_busy = 1'b0; m_base = '0; m_act = 0; m_ma = '0; m_vld = 1'b0; m_data = '0;
        m_tagv = 1'b0; m_tag = '0; m_tagd = '0;
    endtask

    task automatic model_step(input logic c, input logic [31:0] a, input logic r);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (!r) return;
        m_vld = 1'b0;
        if (!m_busy) begin
            if (c) begin
`ifdef INST_FETCH_HIT_EN
                if (m_tagv && wa == m_tag) begin
                    m_vld = 1'b1; m_data = m_tagd;
                    return;
                end
`endif
                m_busy = 1'b1; m_base = wa; m_act = 0; m_ma = wa;
            end
        end else if (!c || wa != m_base) begin
            m_busy = 1'b0;
        end else begin
            m_act++;
            if (m_act == 5) begin
                m_busy = 1'b0; m_vld = 1'b1; m_data = word_at(m_base);
                m_tagv = 1'b1; m_tag = m_base; m_tagd = m_data;
            end else begin
                m_ma = m_base + ((m_act > 3) ? 32'd3 : 32'(m_act));
            end
        end
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h4;
            2: return 32'h8;
            3: return 32'h12;
            4: return 32'hFFFF_FFFC;
            5: return 32'hFFFF_FFFE;
            6: return $urandom;
            default: return $urandom & 32'h3F;
        endcase
    endfunction

    initial begin
        logic        cur_ce;
        logic [31:0] cur_addr;
        logic        cur_rdy;

        rst = 1'b0; ce = 1'b0; addr = '0; rdy = 1'b1;
        model_reset();

        vecs[0]  = '{1'b1, 32'h4, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h4, 1'b1, 32'h4, 1'b0, 1'b1, 32'h0};
        vecs[2]  = '{1'b1, 32'h4, 1'b1, 32'h5, 1'b0, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 32'h4, 1'b1, 32'h6, 1'b0, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 32'h4, 1'b1, 32'h7, 1'b0, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 32'h4, 1'b1, 32'h7, 1'b0, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 32'h4, 1'b1, 32'h7, 1'b1, 1'b0, W4};
        vecs[7]  = '{1'b1, 32'h0, 1'b1, 32'h7, 1'b0, 1'b0, W4};
        vecs[8]  = '{1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, W4};
        vecs[9]  = '{1'b1, 32'h0, 1'b1, 32'h1, 1'b0, 1'b1, W4};
        vecs[10] = '{1'b1, 32'h0, 1'b1, 32'h2, 1'b0, 1'b1, W4};
        vecs[11] = '{1'b1, 32'h0, 1'b1, 32'h3, 1'b0, 1'b1, W4};
        vecs[12] = '{1'b1, 32'h0, 1'b1, 32'h3, 1'b0, 1'b1, W4};
        vecs[13] = '{1'b1, 32'h4, 1'b1, 32'h3, 1'b1, 1'b0, W0};
        vecs[14] = '{1'b1, 32'h4, 1'b1, 32'h4, 1'b0, 1'b1, W0};
        vecs[15] = '{1'b1, 32'h4, 1'b1, 32'h5, 1'b0, 1'b1, W0};
        vecs[16] = '{1'b1, 32'h4, 1'b1, 32'h6, 1'b0, 1'b1, W0};
        vecs[17] = '{1'b1, 32'h4, 1'b1, 32'h7, 1'b0, 1'b1, W0};
        vecs[18] = '{1'b1, 32'h4, 1'b1, 32'h7, 1'b0, 1'b1, W0};
        vecs[19] = '{1'b0, 32'h4, 1'b1, 32'h7, 1'b1, 1'b0, W4};
        vecs[20] = '{1'b0, 32'h4, 1'b1, 32'h7, 1'b0, 1'b0, W4};
        vecs[21] = '{1'b1, 32'h8, 1'b1, 32'h7, 1'b0, 1'b0, W4};
        vecs[22] = '{1'b1, 32'h8, 1'b1, 32'h8, 1'b0, 1'b1, W4};
        vecs[23] = '{1'b1, 32'h8, 1'b1, 32'h9, 1'b0, 1'b1, W4};
        vecs[24] = '{1'b1, 32'hC, 1'b1, 32'hA, 1'b0, 1'b1, W4};
        vecs[25] = '{1'b1, 32'hC, 1'b1, 32'hA, 1'b0, 1'b0, W4};
        vecs[26] = '{1'b1, 32'hC, 1'b1, 32'hC, 1'b0, 1'b1, W4};
        vecs[27] = '{1'b1, 32'hC, 1'b1, 32'hD, 1'b0, 1'b1, W4};
        vecs[28] = '{1'b1, 32'hC, 1'b1, 32'hE, 1'b0, 1'b1, W4};
        vecs[29] = '{1'b1, 32'hC, 1'b1, 32'hF, 1'b0, 1'b1, W4};
        vecs[30] = '{1'b1, 32'hC, 1'b1, 32'hF, 1'b0, 1'b1, W4};
        vecs[31] = '{1'b0, 32'hC, 1'b1, 32'hF, 1'b1, 1'b0, WC};

        @(posedge clk); #1;
        @(negedge clk);
        compare("reset", 32'h0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 32; i++)
            step($sformatf("vec%0d", i), vecs[i].ce, vecs[i].addr, vecs[i].rdy,
                 vecs[i].ma, vecs[i].vld, vecs[i].busy, vecs[i].data);

        // Pause during byte 2 of a fetch of 0x8.
        step("pause_req", 1'b1, 32'h8, 1'b1, 32'hF, 1'b0, 1'b0, WC);
        step("pause_c1",  1'b1, 32'h8, 1'b1, 32'h8, 1'b0, 1'b1, WC);
        step("pause_c2",  1'b1, 32'h8, 1'b1, 32'h9, 1'b0, 1'b1, WC);
        for (int i = 3; i <= 5; i++)
            step($sformatf("pause_hold%0d", i), 1'b1, 32'h8, 1'b0, 32'hA, 1'b0, 1'b1, WC);
        step("pause_c6",  1'b1, 32'h8, 1'b1, 32'hA, 1'b0, 1'b1, WC);
        step("pause_c7",  1'b1, 32'h8, 1'b1, 32'hB, 1'b0, 1'b1, WC);
        step("pause_c8",  1'b1, 32'h8, 1'b1, 32'hB, 1'b0, 1'b1, WC);
        step("pause_vld", 1'b0, 32'h8, 1'b1, 32'hB, 1'b1, 1'b0, W8);

        // Reset asserted in cycle 3 of a fetch, then a clean fetch after release.
        step("rst_req", 1'b1, 32'h4, 1'b1, 32'hB, 1'b0, 1'b0, W8);
        step("rst_c1",  1'b1, 32'h4, 1'b1, 32'h4, 1'b0, 1'b1, W8);
        step("rst_c2",  1'b1, 32'h4, 1'b1, 32'h5, 1'b0, 1'b1, W8);
        rst = 1'b0;
        step("rst_mid",  1'b1, 32'h4, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        step("rst_hold", 1'b1, 32'h4, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        step("rel_req", 1'b1, 32'h10, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 5; i++)
            step($sformatf("rel_c%0d", i), 1'b1, 32'h10, 1'b1,
                 32'h10 + ((i > 4) ? 32'd3 : 32'(i - 1)), 1'b0, 1'b1, 32'h0);
        step("rel_vld", 1'b0, 32'h10, 1'b1, 32'h13, 1'b1, 1'b0, W10);

`ifdef INST_FETCH_HIT_EN
        step("hit_req",  1'b1, 32'h10, 1'b1, 32'h13, 1'b0, 1'b0, W10);
        step("hit_vld",  1'b1, 32'h12, 1'b1, 32'h13, 1'b1, 1'b0, W10);
        step("hit_low2", 1'b0, 32'h12, 1'b1, 32'h13, 1'b1, 1'b0, W10);
        step("hit_end",  1'b0, 32'h12, 1'b1, 32'h13, 1'b0, 1'b0, W10);
`else
        step("refetch_req", 1'b1, 32'h10, 1'b1, 32'h13, 1'b0, 1'b0, W10);
        step("refetch_c1",  1'b1, 32'h12, 1'b1, 32'h10, 1'b0, 1'b1, W10);
        step("refetch_c2",  1'b0, 32'h12, 1'b1, 32'h11, 1'b0, 1'b1, W10);
        step("refetch_abt", 1'b0, 32'h12, 1'b1, 32'h11, 1'b0, 1'b0, W10);
`endif

        // Randomized run against the transaction model.
        rst = 1'b0; ce = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        cur_ce = 1'b1;
        cur_addr = pick_addr();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) cur_ce = ~cur_ce;
            if ($urandom_range(0, 11) == 0) cur_addr = pick_addr();
            cur_rdy = ($urandom_range(0, 99) < 85);
            ce = cur_ce; addr = cur_addr; rdy = cur_rdy;
            @(negedge clk);
            compare($sformatf("rand%0d", i), m_ma, m_vld, m_busy, m_data);
            @(posedge clk);
            model_step(cur_ce, cur_addr, cur_rdy);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "time limit");
    end

endmodule
